// File: rtl/instruction_prefetch_queue_if.sv
// Fetch-side bus bundle for instruction_prefetch_queue: instruction memory port,
// EX branch redirect, hazard stall and the IF/OF-facing instruction slot.
interface instruction_prefetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 8
) ();
  localparam int FILL_W = $clog2(DEPTH) + 1;

  // imem has no ready: a request in cycle N returns imem_rdata in cycle N+1.
  // if_output/if_valid are a registered slot; data_stall means OF holds it.
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [23:0]       imem_rdata;
  logic [PC_W:0]     branch_in;
  logic              data_stall;
  logic [23:0]       if_output;
  logic              if_valid;
  logic [FILL_W-1:0] fill_level;

  modport master (
    output imem_req, imem_addr, if_output, if_valid, fill_level,
    input  imem_rdata, branch_in, data_stall
  );

  modport slave (
    input  imem_req, imem_addr, if_output, if_valid, fill_level,
    output imem_rdata, branch_in, data_stall
  );
endinterface

// File: rtl/instruction_prefetch_queue.sv
// PC sequencer + prefetch FIFO between instruction memory and the IF/OF register.
// Optional PREFETCH_PERF_COUNTERS_EN adds stall/bubble/flush performance counters.
module instruction_prefetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PC_W     = 8,
  parameter logic [23:0] NOP_WORD = 24'h000800
) (
  input  logic clk,
  input  logic rst_n,
  instruction_prefetch_queue_if.master bus
`ifdef PREFETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_bubble_cycles,
  output logic [31:0] perf_flush_count
`endif
);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FILL_W = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]   pc;
  logic              inflight;
  logic              inflight_epoch;
  logic              epoch;
  logic [23:0]       mem [DEPTH];
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr;
  logic [FILL_W-1:0] count;
  logic [23:0]       out_q;
  logic              valid_q;

  logic              taken;
  logic [PC_W-1:0]   target;
  logic [FILL_W-1:0] reserved;
  logic              req;
  logic              push;
  logic              pop;
  logic              bubble;

  assign taken  = bus.branch_in[PC_W];
  assign target = bus.branch_in[PC_W-1:0];

  // Counting the in-flight read as occupied guarantees its push always has room.
  assign reserved = count + FILL_W'(inflight);
  assign req      = rst_n && !taken && (reserved < FILL_W'(DEPTH));
  assign push     = inflight && (inflight_epoch == epoch) && !taken;
  assign pop      = !taken && !bus.data_stall && (count != '0);
  assign bubble   = !taken && !bus.data_stall && (count == '0);

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.if_output  = out_q;
  assign bus.if_valid   = valid_q;
  assign bus.fill_level = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc             <= '0;
      inflight       <= 1'b0;
      inflight_epoch <= 1'b0;
      epoch          <= 1'b0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      out_q          <= NOP_WORD;
      valid_q        <= 1'b0;
    end else begin
      if (req) begin
        pc             <= pc + PC_W'(1);
        inflight       <= 1'b1;
        inflight_epoch <= epoch;
      end else begin
        inflight <= 1'b0;
      end

      if (taken) begin
        // Toggling the epoch orphans any read still returning from the old path.
        epoch   <= ~epoch;
        pc      <= target;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
        out_q   <= NOP_WORD;
        valid_q <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + FILL_W'(push) - FILL_W'(pop);

        if (!bus.data_stall) begin
          if (count != '0) begin
            out_q   <= mem[rd_ptr];
            valid_q <= 1'b1;
          end else begin
            out_q   <= NOP_WORD;
            valid_q <= 1'b0;
          end
        end
      end
    end
  end

`ifdef PREFETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cycles  <= '0;
      perf_bubble_cycles <= '0;
      perf_flush_count   <= '0;
    end else begin
      if (bus.data_stall && !taken && (perf_stall_cycles != 32'hFFFF_FFFF)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (bubble && (perf_bubble_cycles != 32'hFFFF_FFFF)) begin
        perf_bubble_cycles <= perf_bubble_cycles + 32'd1;
      end
      if (taken && (perf_flush_count != 32'hFFFF_FFFF)) begin
        perf_flush_count <= perf_flush_count + 32'd1;
      end
    end
  end
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif
endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Directed bench for instruction_prefetch_queue: startup, stall, branch flush,
// branch+stall, PC wrap and mid-stream reset, against a one-cycle imem model.
module tb_instruction_prefetch_queue;
  localparam int          DEPTH = 4;
  localparam int          PC_W  = 8;
  localparam logic [23:0] NOP   = 24'h000800;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  instruction_prefetch_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

`ifdef PREFETCH_PERF_COUNTERS_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_bubble_cycles;
  logic [31:0] perf_flush_count;
`endif

  instruction_prefetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .NOP_WORD(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PREFETCH_PERF_COUNTERS_EN
    ,
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_bubble_cycles (perf_bubble_cycles),
    .perf_flush_count   (perf_flush_count)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instruction memory: word = 24'h100000 + address, one cycle after request
  always @(posedge clk) begin
    if (bus.imem_req) begin
      bus.imem_rdata <= 24'h100000 + {16'h0, bus.imem_addr};
    end
  end

  always @(negedge clk) begin
    if (bus.fill_level > DEPTH) begin
      miscompares++;
      $display("FAIL fifo_overflow fill_level=%0d exceeds %0d", bus.fill_level, DEPTH);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.branch_in  = '0;
    bus.data_stall = 1'b0;
    step();
    step();
    vectors++;
    if (bus.if_output !== NOP) begin
      miscompares++; $display("FAIL reset_out got %h want %h", bus.if_output, NOP);
    end
    vectors++;
    if (bus.if_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid got %b want 0", bus.if_valid);
    end
    vectors++;
    if (bus.imem_req !== 1'b0) begin
      miscompares++; $display("FAIL reset_req got %b want 0", bus.imem_req);
    end
    vectors++;
    if (bus.fill_level !== 3'd0) begin
      miscompares++; $display("FAIL reset_fill got %0d want 0", bus.fill_level);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL first_req got req=%b addr=%h want req=1 addr=00", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_startup();
    logic [23:0] exp;
    for (int k = 0; k < 6; k++) begin
      step();
      exp = (k < 2) ? NOP : 24'h100000 + 24'(k - 2);
      vectors++;
      if (bus.if_output !== exp || bus.if_valid !== (k >= 2)) begin
        miscompares++;
        $display("FAIL startup[%0d] got %h/%b want %h/%b", k, bus.if_output, bus.if_valid, exp, k >= 2);
      end
    end
    vectors++;
    if (bus.fill_level !== 3'd1) begin
      miscompares++; $display("FAIL steady_fill got %0d want 1", bus.fill_level);
    end
  endtask

  task automatic test_stall();
    logic [2:0] exp_fill [6];
    exp_fill = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
    bus.data_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++;
      if (bus.if_output !== 24'h100003 || bus.if_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_hold[%0d] got %h/%b want 100003/1", i, bus.if_output, bus.if_valid);
      end
      vectors++;
      if (bus.fill_level !== exp_fill[i]) begin
        miscompares++;
        $display("FAIL stall_fill[%0d] got %0d want %0d", i, bus.fill_level, exp_fill[i]);
      end
      if (i >= 2) begin
        vectors++;
        if (bus.imem_req !== 1'b0) begin
          miscompares++; $display("FAIL stall_noreq[%0d] got %b want 0", i, bus.imem_req);
        end
      end
    end
    bus.data_stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (bus.if_output !== 24'h100004 + 24'(i) || bus.if_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stall_resume[%0d] got %h/%b want %h/1", i, bus.if_output, bus.if_valid, 24'h100004 + 24'(i));
      end
    end
  endtask

  task automatic test_branch();
    bus.data_stall = 1'b1;
    step();
    vectors++;
    if (bus.fill_level !== 3'd3 || bus.if_output !== 24'h100008) begin
      miscompares++;
      $display("FAIL pre_branch got fill=%0d out=%h want fill=3 out=100008", bus.fill_level, bus.if_output);
    end
    bus.data_stall = 1'b0;
    bus.branch_in  = {1'b1, 8'h40};
    #1;
    vectors++;
    if (bus.imem_req !== 1'b0) begin
      miscompares++; $display("FAIL branch_noreq got %b want 0", bus.imem_req);
    end
    step();
    bus.branch_in = '0;
    vectors++;
    if (bus.if_output !== NOP || bus.if_valid !== 1'b0 || bus.fill_level !== 3'd0) begin
      miscompares++;
      $display("FAIL branch_flush got %h/%b fill=%0d want %h/0 fill=0", bus.if_output, bus.if_valid, bus.fill_level, NOP);
    end
    #1;
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h40) begin
      miscompares++;
      $display("FAIL branch_target_req got req=%b addr=%h want req=1 addr=40", bus.imem_req, bus.imem_addr);
    end
    for (int i = 0; i < 4; i++) begin
      logic [23:0] exp;
      step();
      exp = (i < 2) ? NOP : 24'h100040 + 24'(i - 2);
      vectors++;
      if (bus.if_output !== exp || bus.if_valid !== (i >= 2)) begin
        miscompares++;
        $display("FAIL branch_refill[%0d] got %h/%b want %h/%b", i, bus.if_output, bus.if_valid, exp, i >= 2);
      end
    end
  endtask

  task automatic test_branch_stall();
    bus.data_stall = 1'b1;
    bus.branch_in  = {1'b1, 8'hFE};
    step();
    bus.data_stall = 1'b0;
    bus.branch_in  = '0;
    vectors++;
    if (bus.if_output !== NOP || bus.if_valid !== 1'b0 || bus.fill_level !== 3'd0) begin
      miscompares++;
      $display("FAIL branch_stall got %h/%b fill=%0d want %h/0 fill=0", bus.if_output, bus.if_valid, bus.fill_level, NOP);
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  wrap_addr [4];
    logic [23:0] exp;
    wrap_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        #1;
        vectors++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== wrap_addr[i]) begin
          miscompares++;
          $display("FAIL wrap_addr[%0d] got req=%b addr=%h want req=1 addr=%h", i, bus.imem_req, bus.imem_addr, wrap_addr[i]);
        end
      end
      step();
      exp = (i < 2) ? NOP : 24'h100000 + {16'h0, wrap_addr[(i < 2) ? 0 : i - 2]};
      vectors++;
      if (bus.if_output !== exp || bus.if_valid !== (i >= 2)) begin
        miscompares++;
        $display("FAIL wrap_out[%0d] got %h/%b want %h/%b", i, bus.if_output, bus.if_valid, exp, i >= 2);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.data_stall = 1'b1;
    for (int i = 0; i < 4; i++) step();
    vectors++;
    if (bus.fill_level !== 3'd4) begin
      miscompares++; $display("FAIL full_before_reset got %0d want 4", bus.fill_level);
    end
`ifdef PREFETCH_PERF_COUNTERS_EN
    vectors++;
    if (perf_stall_cycles !== 32'd11 || perf_bubble_cycles !== 32'd6 || perf_flush_count !== 32'd2) begin
      miscompares++;
      $display("FAIL perf_counts got stall=%0d bubble=%0d flush=%0d want 11/6/2", perf_stall_cycles, perf_bubble_cycles, perf_flush_count);
    end
`endif
    rst_n = 1'b0;
    bus.data_stall = 1'b0;
    step();
    vectors++;
    if (bus.if_output !== NOP || bus.if_valid !== 1'b0 || bus.fill_level !== 3'd0 || bus.imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got %h/%b fill=%0d req=%b want %h/0 fill=0 req=0", bus.if_output, bus.if_valid, bus.fill_level, bus.imem_req, NOP);
    end
`ifdef PREFETCH_PERF_COUNTERS_EN
    vectors++;
    if (perf_stall_cycles !== 32'd0 || perf_bubble_cycles !== 32'd0 || perf_flush_count !== 32'd0) begin
      miscompares++;
      $display("FAIL perf_reset got %0d/%0d/%0d want 0/0/0", perf_stall_cycles, perf_bubble_cycles, perf_flush_count);
    end
`endif
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL restart_req got req=%b addr=%h want req=1 addr=00", bus.imem_req, bus.imem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      logic [23:0] exp;
      step();
      exp = (i < 2) ? NOP : 24'h100000;
      vectors++;
      if (bus.if_output !== exp) begin
        miscompares++;
        $display("FAIL restart_out[%0d] got %h want %h", i, bus.if_output, exp);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_startup();
    test_stall();
    test_branch();
    test_branch_stall();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/instruction_prefetch_queue.md
Name: instruction_prefetch_queue

Overview:
- Fetch-side buffer between the instruction memory and the IF/OF pipeline register.
- Sequences the PC, issues one-cycle-latency reads to instruction memory and buffers the returned 24-bit instructions in a small FIFO.
- Presents one instruction per cycle to OF and absorbs data stalls without losing fetched words.
- On a taken branch from EX, flushes all buffered and in-flight words and redirects the PC.

Parameters:
- DEPTH, 4: FIFO entries; power of two, range 2..16.
- PC_W, 8: PC width; matches the branch-target field width.
- NOP_WORD, 24'h000800: bubble instruction (opcode field [11:8]=4'b1000, all other bits 0).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  PC_W  read address, valid while imem_req=1.
- imem_rdata  in  24  read data, valid exactly 1 cycle after the request.
- branch_in  in  PC_W+1  [PC_W]=taken, [PC_W-1:0]=target PC.
- data_stall  in  1  hazard unit holds the OF input this cycle.
- if_output  out  24  instruction to the IF/OF register; NOP_WORD when no valid instruction.
- if_valid  out  1  if_output carries a real fetched instruction.
- fill_level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n=0 at posedge):
  - pc=0, FIFO empty, in-flight flag clear, epoch=0.
  - if_output=NOP_WORD, if_valid=0, imem_req=0, fill_level=0.
  - A reset asserted mid-operation drops all FIFO and in-flight data.
- Request rule:
  - imem_req=1 when (fill_level + inflight) < DEPTH and taken=0.
  - imem_addr=pc.
  - On a request, pc <= pc+1 modulo 2^PC_W; 255 wraps to 0 with no flag.
- Response:
  - The cycle after a request, imem_rdata is pushed if the request's epoch equals the current epoch; otherwise it is discarded.
  - Reservation accounting guarantees a push never finds the FIFO full. Overflow is a design error; the bench checks for it with an assertion.
- Output register, updated at posedge:
  - Branch taken (highest priority): FIFO cleared, in-flight invalidated (epoch toggles), pc <= target, if_output <= NOP_WORD, if_valid <= 0. No request is issued that cycle. The first request to the target goes out the next cycle, and the target instruction appears on if_output 3 cycles after the branch edge.
  - Else if data_stall=1: if_output and if_valid hold; FIFO does not pop; fetching continues until the reservation limit.
  - Else if FIFO non-empty: pop head into if_output, if_valid <= 1.
  - Else: if_output <= NOP_WORD, if_valid <= 0 (bubble).
- Simultaneous push and pop: both occur; fill_level is unchanged.
- Push into an empty FIFO: the word is not bypassed; it becomes visible on if_output on the cycle after the push (FIFO-to-output latency 1).
- Steady state with no stalls: one instruction per cycle after the startup latency. Startup sequence from reset release: request at cycle 0, push at cycle 1, if_output valid at cycle 2.
- taken and data_stall in the same cycle: the branch wins and the stalled instruction is discarded.

Optional Feature:
- Macro: PREFETCH_PERF_COUNTERS_EN.
- Defined:
  - Adds three 32-bit output ports: perf_stall_cycles, perf_bubble_cycles, perf_flush_count.
  - perf_stall_cycles increments each cycle data_stall=1 and taken=0.
  - perf_bubble_cycles increments each cycle a NOP bubble is issued for an empty FIFO.
  - perf_flush_count increments on each taken branch.
  - All three are cleared by reset and saturate at 32'hFFFFFFFF.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then free-run, imem returning 24'h100000+addr → if_output is NOP_WORD for cycles 0–1, then 24'h100000, 24'h100001, … one per cycle with if_valid=1; fill_level never exceeds DEPTH.
- Assert data_stall for 6 cycles while if_output=24'h100003 → if_output holds 24'h100003; fill_level rises to 4 with no further imem_req; after release the sequence 24'h100004… resumes with no gap and no duplicate.
- Taken branch to 8'h40 while FIFO holds 3 words and one read is in flight → next if_output=NOP_WORD with if_valid=0; the in-flight word is dropped; 24'h100040 appears 3 cycles after the branch edge.
- Branch and data_stall asserted together → branch wins; the stalled word is never reissued; if_valid=0 the next cycle.
- Run with pc starting at 8'hFE → addresses FE, FF, 00, 01 in order; outputs follow with no stall.
- Assert rst_n=0 mid-stream with FIFO full → next cycle if_output=NOP_WORD, fill_level=0; fetching restarts at address 0. With PREFETCH_PERF_COUNTERS_EN defined, all counters read 0.
